// File: rtl/apb_timer_slave.sv
// APB completer exposing an up-counting timer with prescaler,
// compare match flag and level interrupt; fixed wait-state count.
module apb_timer_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_paddr,
  input  logic        i_pwrite,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic [31:0] i_pwdata,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] WS_INIT =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e              state_q;
  logic [3:0]          wcnt_q;
  logic [31:0]         prdata_q;

  logic                en_q, en_d;
  logic                ar_q, ar_d;
  logic                ie_q, ie_d;
  logic                match_q, match_d;
  logic [COUNT_W-1:0]  cmp_q, cmp_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]         pre_q, pre_d;
  logic [15:0]         pcnt_q, pcnt_d;

  logic [2:0]          idx;
  logic [31:0]         rdata;
  logic                wr;
  logic                wr_ctrl, wr_cmp, wr_cnt;
  logic                wr_stat, wr_pre;
  logic                tick, hit;
  logic                unused_bits;

  assign idx = i_paddr[4:2];
  assign unused_bits = ^{i_paddr[31:5], i_paddr[1:0], i_pwdata};

  always_comb begin
    rdata = '0;
    unique case (idx)
      3'd0:    rdata[2:0] = {ie_q, ar_q, en_q};
      3'd1:    rdata[COUNT_W-1:0] = cmp_q;
      3'd2:    rdata[COUNT_W-1:0] = cnt_q;
      3'd3:    rdata[0] = match_q;
      3'd4:    rdata[15:0] = pre_q;
      default: rdata = '0;
    endcase
  end

  // A write lands on the edge that ends the single RESP cycle.
  assign wr      = (state_q == S_RESP) && i_psel && i_pwrite;
  assign wr_ctrl = wr && (idx == 3'd0);
  assign wr_cmp  = wr && (idx == 3'd1);
  assign wr_cnt  = wr && (idx == 3'd2);
  assign wr_stat = wr && (idx == 3'd3);
  assign wr_pre  = wr && (idx == 3'd4);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      prdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_psel && !i_penable) begin
            if (WAIT_STATES == 0) begin
              state_q  <= S_RESP;
              prdata_q <= rdata;
            end else begin
              state_q <= S_WAIT;
              wcnt_q  <= WS_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!i_psel) begin
            state_q <= S_IDLE;
          end else if (wcnt_q == 4'd0) begin
            state_q  <= S_RESP;
            prdata_q <= rdata;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q  <= S_IDLE;
          prdata_q <= '0;
        end
        default: begin
          state_q  <= S_IDLE;
          prdata_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    tick    = en_q && (pcnt_q == pre_q);
    hit     = tick && (cnt_q == cmp_q);
    pcnt_d  = (en_q && !tick) ? pcnt_q + 16'd1 : 16'd0;
    en_d    = en_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    match_d = match_q;
    if (tick) begin
      if (hit) begin
        if (ar_q) cnt_d = '0;
        else      en_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end
    // Bus writes override the timer's own update on the same edge.
    if (wr_ctrl) {ie_d, ar_d, en_d} = i_pwdata[2:0];
    if (wr_cmp)  cmp_d = i_pwdata[COUNT_W-1:0];
    if (wr_cnt)  cnt_d = i_pwdata[COUNT_W-1:0];
    if (wr_pre)  pre_d = i_pwdata[15:0];
    if (wr_stat && i_pwdata[0]) match_d = 1'b0;
    if (hit) match_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      match_q <= 1'b0;
      cmp_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      match_q <= match_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign o_pready = (state_q == S_RESP);
  assign o_prdata = prdata_q;
  assign o_irq    = match_q & ie_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Randomized APB traffic against a rule-level timer model,
// plus directed one-shot, reload, race, abort and reset cases.
module tb_apb_timer_slave;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        irq;
  logic        psel0;
  logic        penable0;
  logic [31:0] prdata0;
  logic        pready0;
  logic        irq0;

  always #5 clk = ~clk;

  apb_timer_slave #(.WAIT_STATES(WS), .COUNT_W(32)) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_paddr   (paddr),
    .i_pwrite  (pwrite),
    .i_psel    (psel),
    .i_penable (penable),
    .i_pwdata  (pwdata),
    .o_prdata  (prdata),
    .o_pready  (pready),
    .o_irq     (irq)
  );

  apb_timer_slave #(.WAIT_STATES(0), .COUNT_W(32)) dut0 (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_paddr   (paddr),
    .i_pwrite  (pwrite),
    .i_psel    (psel0),
    .i_penable (penable0),
    .i_pwdata  (pwdata),
    .o_prdata  (prdata0),
    .o_pready  (pready0),
    .o_irq     (irq0)
  );

  int checks = 0;
  int errors = 0;

  bit          m_en, m_ar, m_ie, m_match;
  logic [31:0] m_cmp, m_cnt;
  logic [15:0] m_pre, m_pcnt;
  bit          w_pend;
  logic [2:0]  w_idx;
  logic [31:0] w_data;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
    m_cmp = '0; m_cnt = '0; m_pre = '0; m_pcnt = '0;
  endtask

  function automatic logic [31:0] rd_model(input logic [2:0] i);
    case (i)
      3'd0:    return {29'd0, m_ie, m_ar, m_en};
      3'd1:    return m_cmp;
      3'd2:    return m_cnt;
      3'd3:    return {31'd0, m_match};
      3'd4:    return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    bit          tick, hit, n_en, n_ar, n_ie, n_match;
    logic [31:0] n_cnt, n_cmp;
    logic [15:0] n_pre, n_pcnt;
    tick = m_en && (m_pcnt == m_pre);
    hit  = tick && (m_cnt == m_cmp);
    n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_match = m_match;
    n_cnt = m_cnt; n_cmp = m_cmp; n_pre = m_pre;
    n_pcnt = !m_en ? 16'd0 : (tick ? 16'd0 : m_pcnt + 16'd1);
    if (hit && m_ar)  n_cnt = 0;
    if (hit && !m_ar) n_en = 0;
    if (tick && !hit) n_cnt = m_cnt + 1;
    if (w_pend) begin
      case (w_idx)
        3'd0: begin
          n_en = w_data[0]; n_ar = w_data[1]; n_ie = w_data[2];
        end
        3'd1: n_cmp = w_data;
        3'd2: n_cnt = w_data;
        3'd3: if (w_data[0]) n_match = 0;
        3'd4: n_pre = w_data[15:0];
        default: ;
      endcase
    end
    if (hit) n_match = 1;
    m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_match = n_match;
    m_cnt = n_cnt; m_cmp = n_cmp; m_pre = n_pre; m_pcnt = n_pcnt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_match & m_ie});
  endtask

  task automatic apb(input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, output logic [31:0] rd);
    logic [31:0] exp;
    exp = '0;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    for (int i = 0; i <= WS; i++) begin
      chk("pready_lo", {31'd0, pready}, 32'd0);
      chk("prdata_idle", prdata, 32'd0);
      if (i == WS) exp = rd_model(addr[4:2]);
      step();
      penable = 1;
    end
    chk("pready_hi", {31'd0, pready}, 32'd1);
    if (!wr) chk("prdata", prdata, exp);
    rd = prdata;
    w_pend = wr; w_idx = addr[4:2]; w_data = data;
    step();
    w_pend = 0; psel = 0; penable = 0;
  endtask

  initial begin
    logic [31:0] rd, addr, data;
    logic [2:0]  idx;
    bit          wr;

    rst_n = 0; psel = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; psel0 = 0; penable0 = 0;
    w_pend = 0; w_idx = '0; w_data = '0;
    model_reset();
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    #11;
    rst_n = 1;
    step();

    for (int i = 0; i < 8; i++) begin
      apb(0, 32'(i * 4), 32'd0, rd);
      chk("rst_reg", rd, 32'd0);
    end

    // One-shot: 0..5 then stop with match
    apb(1, 32'h10, 32'h0, rd);
    apb(1, 32'h04, 32'h5, rd);
    apb(1, 32'h08, 32'h0, rd);
    apb(1, 32'h00, 32'h5, rd);
    repeat (12) step();
    apb(0, 32'h0C, 32'h0, rd);
    chk("os_match", rd, 32'd1);
    chk("os_irq", {31'd0, irq}, 32'd1);
    apb(0, 32'h00, 32'h0, rd);
    chk("os_ctrl", rd, 32'd4);
    apb(0, 32'h08, 32'h0, rd);
    chk("os_count", rd, 32'd5);

    // Auto-reload: match exactly 12 cycles after enabling
    apb(1, 32'h00, 32'h0, rd);
    apb(1, 32'h0C, 32'h1, rd);
    apb(1, 32'h10, 32'h3, rd);
    apb(1, 32'h04, 32'h2, rd);
    apb(1, 32'h08, 32'h0, rd);
    apb(1, 32'h00, 32'h7, rd);
    repeat (11) step();
    chk("ar_pre12", {31'd0, irq}, 32'd0);
    step();
    chk("ar_at12", {31'd0, irq}, 32'd1);
    repeat (20) apb(0, 32'h08, 32'h0, rd);

    // W1C racing a match that fires every cycle
    apb(1, 32'h00, 32'h0, rd);
    apb(1, 32'h10, 32'h0, rd);
    apb(1, 32'h04, 32'h0, rd);
    apb(1, 32'h08, 32'h0, rd);
    apb(1, 32'h00, 32'h3, rd);
    apb(1, 32'h0C, 32'h1, rd);
    apb(0, 32'h0C, 32'h0, rd);
    chk("race_set_wins", rd, 32'd1);
    apb(1, 32'h00, 32'h0, rd);
    apb(1, 32'h0C, 32'h1, rd);
    apb(0, 32'h0C, 32'h0, rd);
    chk("w1c_clear", rd, 32'd0);

    apb(1, 32'h18, 32'hFFFF_FFFF, rd);
    apb(0, 32'h18, 32'h0, rd);
    chk("unmapped", rd, 32'd0);

    // Abort a COUNT write during the wait phase
    apb(1, 32'h08, 32'h55, rd);
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h08; pwdata = 32'hAA;
    step();
    psel = 0;
    step();
    chk("abort_rdy", {31'd0, pready}, 32'd0);
    step();
    chk("abort_rdy2", {31'd0, pready}, 32'd0);
    apb(0, 32'h08, 32'h0, rd);
    chk("abort_count", rd, 32'h55);

    for (int n = 0; n < 200; n++) begin
      idx  = 3'($urandom_range(0, 7));
      wr   = 1'($urandom_range(0, 1));
      addr = $urandom();
      addr[4:2] = idx;
      data = $urandom();
      if (idx == 3'd4) data[15:0] = 16'($urandom_range(0, 5));
      if (idx == 3'd1) data = $urandom_range(0, 6);
      if (idx == 3'd2)
        data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD
                                           : $urandom_range(0, 4);
      apb(wr, addr, data, rd);
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset asserted mid-wait
    apb(1, 32'h04, 32'h0, rd);
    apb(1, 32'h00, 32'h7, rd);
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h08;
    step();
    penable = 1;
    rst_n = 0;
    #1;
    chk("rstw_pready", {31'd0, pready}, 32'd0);
    chk("rstw_prdata", prdata, 32'd0);
    chk("rstw_irq", {31'd0, irq}, 32'd0);
    psel = 0; penable = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      apb(0, 32'(i * 4), 32'd0, rd);
      chk("rstw_reg", rd, 32'd0);
    end

    // Zero-wait-state instance
    psel0 = 1; penable0 = 0; pwrite = 1; paddr = 32'h04;
    pwdata = 32'h1234;
    chk("ws0_setup", {31'd0, pready0}, 32'd0);
    step();
    chk("ws0_rdy", {31'd0, pready0}, 32'd1);
    penable0 = 1;
    step();
    chk("ws0_idle", {31'd0, pready0}, 32'd0);
    psel0 = 1; penable0 = 0; pwrite = 0;
    step();
    chk("ws0_rd_rdy", {31'd0, pready0}, 32'd1);
    chk("ws0_rd", prdata0, 32'h1234);
    penable0 = 1;
    step();
    psel0 = 0; penable0 = 0;
    chk("ws0_after", prdata0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
